// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one external 32-bit ALU to two requesters.
// The operation goes through request, one execute cycle, then a held response.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_ALUControl,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_ALUControl,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_Result,
    output logic [3:0]       rsp_Flags,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Result,
    input  logic             oVerflow,
    input  logic             Carry,
    input  logic             Negative,
    input  logic             Zero,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic             r_gnt_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic w_any;
    logic w_gnt;
    logic w_idle;
    logic w_rsp_hs;

    assign w_any  = req0_valid | req1_valid;
    // With both requesters waiting the priority pointer decides, otherwise the lone one wins.
    assign w_gnt  = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign w_idle = (r_state == IDLE);

    assign req0_ready = w_idle && w_any && !w_gnt;
    assign req1_ready = w_idle && w_any && w_gnt;

    assign rsp0_valid = (r_state == RESP) && !r_gnt_id;
    assign rsp1_valid = (r_state == RESP) && r_gnt_id;
    assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign rsp_Result  = r_result;
    assign rsp_Flags   = r_flags;
    assign ALUControl  = r_op;
    assign A           = r_a;
    assign B           = r_b;
    assign busy        = !w_idle;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_gnt_id <= 1'b0;
            r_op     <= 3'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_id <= w_gnt;
                        r_op     <= w_gnt ? req1_ALUControl : req0_ALUControl;
                        r_a      <= w_gnt ? req1_A : req0_A;
                        r_b      <= w_gnt ? req1_B : req0_B;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= Result;
                    r_flags  <= {oVerflow, Carry, Negative, Zero};
                    r_state  <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_prio  <= ~r_gnt_id;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model closes the loop, directed vectors
// plus hand-written sequences for fairness, back-pressure and mid-operation reset.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_v, alu_c, alu_n, alu_z;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [32:0] alu_sum;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
        .req0_ALUControl(req_op[0]), .req0_A(req_a[0]), .req0_B(req_b[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
        .req1_ALUControl(req_op[1]), .req1_A(req_a[1]), .req1_B(req_b[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
        .rsp_Result(rsp_result), .rsp_Flags(rsp_flags),
        .ALUControl(alu_op), .A(alu_a), .B(alu_b),
        .Result(alu_res), .oVerflow(alu_v), .Carry(alu_c),
        .Negative(alu_n), .Zero(alu_z),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // External ALU model
    always_comb begin
        alu_sum = 33'd0;
        alu_res = 32'd0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            3'b001: begin
                alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a | alu_b;
            3'b101: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = 32'd0;
        endcase
        alu_n = alu_res[31];
        alu_z = (alu_res == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [10];

    // Driver: one full operation with rsp_ready held high, checked cycle by cycle.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid[v.id] = 1'b1;
        req_op[v.id]    = v.op;
        req_a[v.id]     = v.a;
        req_b[v.id]     = v.b;
        #1;
        check("req_ready_c0", 32'(req_ready), v.id ? 32'd2 : 32'd1);
        check("busy_c0", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid[v.id] = 1'b0;
        req_op[v.id]    = 3'b110;
        req_a[v.id]     = 32'hDEADBEEF;
        req_b[v.id]     = 32'hCAFEF00D;
        #1;
        check("busy_exec", 32'(busy), 32'd1);
        check("alu_op_exec", 32'(alu_op), 32'(v.op));
        check("alu_a_exec", alu_a, v.a);
        check("alu_b_exec", alu_b, v.b);
        check("rsp_valid_exec", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("rsp_valid_c2", 32'(rsp_valid), v.id ? 32'd2 : 32'd1);
        check("rsp_result", rsp_result, v.exp_res);
        check("rsp_flags", 32'(rsp_flags), 32'(v.exp_flags));
        check("busy_resp", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("busy_after", 32'(busy), 32'd0);
        check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int grants;
        int rsps;
        int cyc;
        logic last_gnt;

        // {id, op, A, B, result, {V,C,N,Z}}
        vecs[0] = '{1'b0, 3'b000, 32'd6, 32'd4, 32'h0000000A, 4'b0000};
        vecs[1] = '{1'b1, 3'b001, 32'd4, 32'd6, 32'hFFFFFFFE, 4'b0010};
        vecs[2] = '{1'b1, 3'b001, 32'd5, 32'd5, 32'h00000000, 4'b0101};
        vecs[3] = '{1'b0, 3'b000, 32'd7, 32'd8, 32'h0000000F, 4'b0000};
        vecs[4] = '{1'b0, 3'b001, 32'd3, 32'd1, 32'h00000002, 4'b0100};
        vecs[5] = '{1'b0, 3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000};
        vecs[6] = '{1'b0, 3'b011, 32'd1, 32'd2, 32'h00000003, 4'b0000};
        vecs[7] = '{1'b0, 3'b101, 32'hFFFFFFFF, 32'd1, 32'h00000001, 4'b0000};
        vecs[8] = '{1'b0, 3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1010};
        vecs[9] = '{1'b0, 3'b111, 32'd5, 32'd9, 32'h00000000, 4'b0001};

        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = 3'd0;
            req_a[i]  = 32'd0;
            req_b[i]  = 32'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", 32'(rsp_flags), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Single-requester operations
        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Both requesters valid continuously: grants alternate starting from requester 0
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
        grants   = 0;
        rsps     = 0;
        cyc      = 0;
        last_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = 3'b011;
            req_a[i]  = 32'h000000F0;
            req_b[i]  = 32'h0000000F;
        end
        while (rsps < 4 && cyc < 60) begin
            @(negedge clk);
            req_valid = (grants < 4) ? 2'b11 : 2'b00;
            #1;
            cyc++;
            check("ready_exclusive", 32'(req_ready == 2'b11), 32'd0);
            if (req_ready != 2'b00) begin
                last_gnt = req_ready[1];
                if (exp_q.size() > 0) check("grant_order", 32'(last_gnt), exp_q.pop_front());
                grants++;
            end
            if (rsp_valid != 2'b00) begin
                check("fair_rsp_id", 32'(rsp_valid), last_gnt ? 32'd2 : 32'd1);
                check("fair_result", rsp_result, 32'h000000FF);
                rsps++;
            end
        end
        req_valid = 2'b00;
        check("fair_grants", 32'(grants), 32'd4);
        check("fair_rsps", 32'(rsps), 32'd4);
        @(negedge clk);

        // Back-pressure: response held while a rival request is waiting
        rsp_ready    = 2'b00;
        req_valid[0] = 1'b1;
        req_op[0]    = 3'b010;
        req_a[0]     = 32'h000000FF;
        req_b[0]     = 32'h0000000F;
        #1;
        check("bp_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_op[1]    = 3'b000;
        req_a[1]     = 32'd1;
        req_b[1]     = 32'd1;
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, 32'h0000000F);
            check("bp_req1_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready    = 2'b11;
        req_valid[1] = 1'b0;
        @(negedge clk);
        #1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);

        // Reset during EXEC aborts the operation and restores priority to requester 0
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_op[0]    = 3'b101;
        req_a[0]     = 32'd6;
        req_b[0]     = 32'd4;
        #1;
        check("ar_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        check("ar_exec", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar_result", rsp_result, 32'd0);
        check("ar_flags", 32'(rsp_flags), 32'd0);
        check("ar_alu_op", 32'(alu_op), 32'd0);
        check("ar_alu_a", alu_a, 32'd0);
        check("ar_alu_b", alu_b, 32'd0);
        #2;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("ar_no_rsp", 32'(rsp_valid), 32'd0);
            check("ar_idle", 32'(busy), 32'd0);
        end
        @(negedge clk);
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = 3'b000;
            req_a[i]  = 32'd1;
            req_b[i]  = 32'd1;
        end
        #1;
        check("ar_prio_reset", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("ar_next_rsp", 32'(rsp_valid), 32'd1);
        check("ar_next_result", rsp_result, 32'd2);
        @(negedge clk);

        // Every opcode through requester 0, including a forwarded reserved one
        for (int i = 3; i < 10; i++) run_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the 32-bit ALU between two requesters, for example the datapath and a debug/ACU port. Each requester issues an operation over a valid/ready handshake. The arbiter grants requests round-robin, latches the operands, drives the ALU for one cycle, registers Result and the VCNZ flags, and returns them over a per-requester valid/ready response handshake. The ALU instance sits outside this block; the arbiter drives its inputs and samples its outputs.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_ALUControl  input  3  requester 0 opcode (000 add, 001 sub, 010 and, 011 or, 101 slt)
req0_A, req0_B  input  WIDTH  requester 0 operands
req1_valid, req1_ready, req1_ALUControl, req1_A, req1_B  same as above, requester 1
rsp0_valid  output  1  response for requester 0 available
rsp0_ready  input  1  requester 0 consumes the response
rsp1_valid, rsp1_ready  same as above, requester 1
rsp_Result  output  WIDTH  registered ALU result (shared by both response channels)
rsp_Flags  output  4  registered {V,C,N,Z}
ALUControl  output  3  to ALU
A, B  output  WIDTH  to ALU
Result  input  WIDTH  from ALU
oVerflow, Carry, Negative, Zero  input  1 each  from ALU flags
busy  output  1  high in EXEC or RESP

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Priority pointer prio (1 bit): reset value 0; it names the favoured requester.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant requester prio.
  - The granted reqN_ready is combinational: it is high only in IDLE and only for the granted requester.
  - On the handshake edge, latch opcode, A and B into the operand registers, record gnt_id, and go to EXEC.
- EXEC (exactly 1 cycle):
  - ALUControl, A and B output the latched values.
  - On the clock edge, capture Result into rsp_Result and {oVerflow,Carry,Negative,Zero} into rsp_Flags, then go to RESP.
- RESP:
  - rspN_valid is high for N = gnt_id only.
  - rsp_Result and rsp_Flags hold steady until the handshake.
  - On the edge where rspN_valid and rspN_ready are both high, set prio to the complement of gnt_id and go to IDLE.
  - With no ready, stay in RESP indefinitely; the outputs must not change.
- Latency and throughput:
  - Request accepted at edge T; rsp valid from cycle T+2.
  - A same-cycle rsp_ready gives minimum 3 cycles per operation.
  - A new request is accepted only in IDLE, so requests never overlap.
- ALU drive outputs:
  - ALUControl, A and B are registered.
  - They hold their last latched value outside EXEC; reset value is 0.
- Opcodes 100, 110 and 111 are forwarded unchanged, with no checking. Result and flags are whatever the ALU returns.
- Request inputs are sampled only at the handshake edge. Changes on a non-granted requester while the arbiter is busy are ignored. A requester whose valid drops before it is granted loses nothing.
- Reset values:
  - req0_ready, req1_ready, rsp0_valid, rsp1_valid and busy: 0.
  - rsp_Result and rsp_Flags: 0.
  - gnt_id: 0.
- Reset mid-operation (EXEC or RESP): abort immediately (asynchronous), drop the pending response, return to IDLE with prio 0. No response is ever issued for the aborted operation.
- Fairness: when both requesters stay valid, grants strictly alternate 0,1,0,1… starting from prio.

Test Plan:
1. Reset. req0 add, A=6, B=4; rsp0_ready held high. Required: req0_ready high in cycle 0, rsp0_valid in cycle 2, rsp_Result=32'h0000000A, busy high for 2 cycles.
2. req1 sub, A=4, B=6. Required: rsp1_valid only, rsp_Result=32'hFFFFFFFE, rsp_Flags N=1, Z=0. Separately, sub with A=5, B=5. Required: rsp_Result=0, Z=1.
3. Both valid continuously, each issuing or (A=32'hF0, B=32'h0F) with ready high. Required: grant order 0,1,0,1; each result 32'h000000FF; no cycle with both readys high.
4. req0 and (A=32'hFF, B=32'h0F) with rsp0_ready held low for 5 cycles. Required: rsp0_valid stays high, rsp_Result stays 32'h0000000F, req1_ready stays 0 throughout even while req1_valid is high.
5. req0 slt, A=6, B=4, rst pulsed during EXEC. Required: all outputs return to reset values asynchronously; no rsp0_valid afterwards; the next simultaneous request grants requester 0.
6. Each of the five opcodes issued in turn through req0. Required: ALUControl, A and B match the latched request during EXEC; rsp_Flags equal the ALU flag outputs sampled in EXEC.
